vending_machine_param: RTL

VENDING_MACHINE_PARAM -- requirements
Module: vending_machine_param

---
 rtl/vm_pkg.sv | 27 ++
 rtl/vm_change_gen.sv | 24 ++
 rtl/vending_machine_param.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/vm_pkg.sv
// Shared types and coin helpers for the parameterised vending machine.
package vm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } vm_state_t;

    localparam logic [1:0] COIN_5  = 2'b00;
    localparam logic [1:0] COIN_10 = 2'b01;
    localparam logic [1:0] COIN_20 = 2'b10;
    localparam logic [1:0] COIN_50 = 2'b11;

    localparam int COIN_VAL_W = 6;

    function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_5:  return 6'd5;
            COIN_10: return 6'd10;
            COIN_20: return 6'd20;
            default: return 6'd50;
        endcase
    endfunction

endpackage

// File: rtl/vm_change_gen.sv
// Greedy change selector: largest coin not exceeding the remaining credit.
module vm_change_gen
    import vm_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic [CREDIT_W-1:0] credit,
    output logic [1:0]          coin_code,
    output logic [CREDIT_W-1:0] coin_val
);

    always_comb begin
        coin_code = COIN_5;
        if (credit >= CREDIT_W'(50)) begin
            coin_code = COIN_50;
        end else if (credit >= CREDIT_W'(20)) begin
            coin_code = COIN_20;
        end else if (credit >= CREDIT_W'(10)) begin
            coin_code = COIN_10;
        end
        coin_val = (credit == '0) ? '0 : CREDIT_W'(coin_value(coin_code));
    end

endmodule

// File: rtl/vending_machine_param.sv
// Parameterised vending machine controller; per-item stock tracking is
// compiled in only when VM_STOCK_EN is defined.
//
// state     | meaning
// ST_IDLE   | no credit, waiting for a coin
// ST_CREDIT | credit held, accepting coins / selection / cancel
// ST_VEND   | single dispense cycle
// ST_CHANGE | paying out remaining credit, one coin per cycle
module vending_machine_param
    import vm_pkg::*;
#(
    parameter int NUM_ITEMS  = 4,
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 200,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_LIST = {8'd5, 8'd10, 8'd15, 8'd20},
    parameter int INIT_STOCK = 3,
    localparam int SEL_W = $clog2(NUM_ITEMS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 coin_valid,
    input  logic [1:0]           coin,
    input  logic                 sel_valid,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 cancel,
    output logic                 vend,
    output logic [SEL_W-1:0]     vend_item,
    output logic                 change_valid,
    output logic [1:0]           change_coin,
    output logic [CREDIT_W-1:0]  credit,
    output logic                 coin_reject,
    output logic                 busy,
    output logic [NUM_ITEMS-1:0] sold_out
);

    localparam int SEL_SPAN = 2 ** SEL_W;
    localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W + 1)'(MAX_CREDIT);

    if (NUM_ITEMS < 2 || NUM_ITEMS > 16 || INIT_STOCK < 0) begin : g_param_check
        $error("vending_machine_param: NUM_ITEMS must be 2..16 and INIT_STOCK >= 0");
    end

    vm_state_t             state_q, state_d;
    logic [CREDIT_W-1:0]   credit_d;
    logic                  vend_d, chg_valid_d, reject_d;
    logic [SEL_W-1:0]      vend_item_d;
    logic [1:0]            chg_coin_d, gen_code;
    logic [CREDIT_W-1:0]   gen_val;
    logic [CREDIT_W:0]     coin_sum;
    logic                  coin_fits, sel_ok;
    logic [NUM_ITEMS-1:0]  sold_out_q;

    // Pad the lookup tables to the full select range so out-of-range
    // selections simply read as non-existent items.
    logic [CREDIT_W-1:0]   price_tab [SEL_SPAN];
    logic [SEL_SPAN-1:0]   item_exists, item_empty;

    for (genvar i = 0; i < SEL_SPAN; i++) begin : g_tab
        if (i < NUM_ITEMS) begin : g_real
            assign price_tab[i]   = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
            assign item_exists[i] = 1'b1;
            assign item_empty[i]  = sold_out_q[i];
        end else begin : g_pad
            assign price_tab[i]   = '0;
            assign item_exists[i] = 1'b0;
            assign item_empty[i]  = 1'b1;
        end
    end

    vm_change_gen #(.CREDIT_W(CREDIT_W)) u_change_gen (
        .credit    (credit),
        .coin_code (gen_code),
        .coin_val  (gen_val)
    );

    assign coin_sum  = {1'b0, credit} + (CREDIT_W + 1)'(coin_value(coin));
    assign coin_fits = (coin_sum <= MAX_C);
    assign sel_ok    = sel_valid && item_exists[sel] && !item_empty[sel]
                       && (credit >= price_tab[sel]);

    always_comb begin
        state_d     = state_q;
        credit_d    = credit;
        vend_d      = 1'b0;
        vend_item_d = '0;
        chg_valid_d = 1'b0;
        chg_coin_d  = COIN_5;
        reject_d    = 1'b0;
        case (state_q)
            ST_IDLE, ST_CREDIT: begin
                if (state_q == ST_CREDIT && cancel) begin
                    state_d  = ST_CHANGE;
                    reject_d = coin_valid;
                end else if (state_q == ST_CREDIT && sel_ok) begin
                    vend_d      = 1'b1;
                    vend_item_d = sel;
                    credit_d    = credit - price_tab[sel];
                    state_d     = ST_VEND;
                    reject_d    = coin_valid;
                end else if (coin_valid) begin
                    if (coin_fits) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = ST_CREDIT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            ST_VEND: begin
                reject_d = coin_valid;
                state_d  = (credit != '0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                reject_d = coin_valid;
                if (credit == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    chg_valid_d = 1'b1;
                    chg_coin_d  = gen_code;
                    credit_d    = credit - gen_val;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            credit       <= '0;
            vend         <= 1'b0;
            vend_item    <= '0;
            change_valid <= 1'b0;
            change_coin  <= '0;
            coin_reject  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit       <= credit_d;
            vend         <= vend_d;
            vend_item    <= vend_item_d;
            change_valid <= chg_valid_d;
            change_coin  <= chg_coin_d;
            coin_reject  <= reject_d;
            busy         <= (state_d == ST_VEND) || (state_d == ST_CHANGE);
        end
    end

`ifdef VM_STOCK_EN
    localparam int STOCK_W = (INIT_STOCK < 1) ? 1 : $clog2(INIT_STOCK + 1);
    logic [STOCK_W-1:0] stock_q [NUM_ITEMS];

    // Stock and sold_out update on the same edge that issues the vend pulse.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (!reset) begin
                stock_q[i]    <= STOCK_W'(INIT_STOCK);
                sold_out_q[i] <= (INIT_STOCK == 0);
            end else if (vend_d && vend_item_d == SEL_W'(i)) begin
                stock_q[i]    <= stock_q[i] - STOCK_W'(1);
                sold_out_q[i] <= (stock_q[i] == STOCK_W'(1));
            end
        end
    end
`else
    assign sold_out_q = '0;
`endif

    assign sold_out = sold_out_q;

endmodule
